baud_tick_gen: RTL and testbench
================================

BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, input clock frequency in Hz; used only to derive reset divisor.
REQ-002 Parameter OVERSAMPLE, default 16, oversample ticks per bit; legal values even, 4..32.
REQ-003 Parameter DIV_W, default 16, width of integer divisor.
REQ-004 Parameter FRAC_W, default 4, width of fractional divisor.
REQ-005 Parameter RST_BAUD, default 9600, baud rate loaded at reset.
REQ-006 clk  input  1  clock.
REQ-007 arst_n  input  1  reset, asynchronous, active-low.
REQ-008 en  input  1  generator run enable, level.
REQ-009 load  input  1  single-cycle request to load div_int/div_frac.
REQ-010 div_int  input  DIV_W  integer clocks per oversample tick.
REQ-011 div_frac  input  FRAC_W  fractional clocks per oversample tick, units of 2^-FRAC_W.
REQ-012 os_tick  output  1  one-cycle oversample strobe.
REQ-013 mid_tick  output  1  one-cycle strobe at bit centre (RX sampling).
REQ-014 bit_tick  output  1  one-cycle strobe at bit end (TX shifting).
REQ-015 load_ack  output  1  one-cycle pulse, divisor accepted.
REQ-016 cfg_err  output  1  sticky, last load rejected.

Function
REQ-017 Active divisor (act_int, act_frac) and pending divisor (pnd_int, pnd_frac, pnd_valid) SHALL be registered.
REQ-018 States SHALL be IDLE (en=0) and RUN (en=1); IDLE->RUN on first cycle en=1, RUN->IDLE on first cycle en=0.
REQ-019 In IDLE: period counter, sub-tick counter and fractional accumulator SHALL be held at 0; os_tick, mid_tick, bit_tick SHALL be 0.
REQ-020 On IDLE->RUN, period counter SHALL load act_int-1 (pending applied first if pnd_valid); first os_tick SHALL assert exactly act_int cycles after the first en=1 cycle.
REQ-021 os_tick SHALL assert in each RUN cycle with period counter = 0; that cycle the counter SHALL reload act_int-1+carry, where {carry, acc_next} = acc + act_frac (FRAC_W+1 bit add), acc <= acc_next.
REQ-022 Mean os_tick period SHALL be act_int + act_frac/2^FRAC_W cycles; individual periods only act_int or act_int+1.
REQ-023 Sub-tick counter SHALL increment modulo OVERSAMPLE on each os_tick.
REQ-024 mid_tick SHALL assert coincident with os_tick when sub-tick counter = OVERSAMPLE/2-1; bit_tick SHALL assert coincident with os_tick when sub-tick counter = OVERSAMPLE-1.
REQ-025 load with div_int >= 2 SHALL write pending registers, set pnd_valid, pulse load_ack next cycle, clear cfg_err.
REQ-026 load with div_int < 2 SHALL leave pending unchanged, give no load_ack, set cfg_err next cycle.
REQ-027 A second valid load before application SHALL overwrite pending; load_ack pulses for each.
REQ-028 Pending SHALL transfer to active in an os_tick cycle (new value governs the following period; acc and sub-tick counter untouched) or in any IDLE cycle; pnd_valid then clears.
REQ-029 load in same cycle as os_tick SHALL be applied at the next os_tick, not the current one.
REQ-030 en falling mid-bit SHALL abort immediately with no partial ticks; next RUN starts a fresh bit.

Reset
REQ-031 arst_n low SHALL asynchronously force: all outputs 0, counters and acc 0, pnd_valid 0, cfg_err 0, state IDLE.
REQ-032 Reset active divisor: act_int = floor(CLK_FREQ/(OVERSAMPLE*RST_BAUD)), act_frac = floor(fractional remainder * 2^FRAC_W); defaults give 325 and 8.
REQ-033 Deassertion SHALL be synchronised to clk.

Verification
REQ-034 Load div_int=4, div_frac=0, en=1 -> os_tick every 4 cycles, mid_tick every 64 cycles (first at cycle 32), bit_tick every 64 cycles (first at cycle 64).
REQ-035 div_int=4, div_frac=8, FRAC_W=4 -> periods 4,4,5,4,5,...; any 32 consecutive periods total 144 cycles.
REQ-036 load div_int=1 -> cfg_err=1, no load_ack, tick spacing unchanged; then load div_int=6 -> load_ack, cfg_err=0, period 6 from the os_tick after load.
REQ-037 Drop en for 1 cycle after 7 os_ticks -> no ticks during IDLE; first os_tick act_int cycles after en returns; bit_tick after 16 further os_ticks.
REQ-038 Assert arst_n low mid-run -> outputs 0 same cycle; after release and en=1, os_tick period 325/326 with default parameters.

Source files
------------

// File: rtl/baud_tick_gen.sv
// Fractional-N baud tick generator: oversample strobe plus bit-centre and bit-end strobes,
// with a double-buffered divisor that is swapped only on a tick boundary or while idle.
module baud_tick_gen #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4,
    parameter int RST_BAUD   = 9600
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              en,
    input  logic              load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic              load_ack,
    output logic              cfg_err
);

    localparam longint unsigned DEN      = longint'(OVERSAMPLE) * longint'(RST_BAUD);
    localparam longint unsigned CLK_L    = longint'(CLK_FREQ);
    localparam longint unsigned RST_I_L  = CLK_L / DEN;
    localparam longint unsigned RST_F_L  = ((CLK_L % DEN) << FRAC_W) / DEN;
    localparam logic [DIV_W-1:0]  RST_INT  = RST_I_L[DIV_W-1:0];
    localparam logic [FRAC_W-1:0] RST_FRAC = RST_F_L[FRAC_W-1:0];
    localparam int SUB_W = $clog2(OVERSAMPLE);
    localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_nxt;

    logic [1:0]        rst_ff;
    logic              rst_n;
    logic [DIV_W-1:0]  act_int, pnd_int, eff_int;
    logic [FRAC_W-1:0] act_frac, pnd_frac, eff_frac;
    logic              pnd_valid, use_pnd;
    logic [DIV_W-1:0]  cnt, cnt_nxt;
    logic [FRAC_W-1:0] acc, acc_nxt, acc_sum;
    logic              carry;
    logic [SUB_W-1:0]  sub, sub_nxt;

    // Assert asynchronously, release only on a clock edge.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) rst_ff <= 2'b00;
        else         rst_ff <= {rst_ff[0], 1'b1};
    end
    assign rst_n = rst_ff[1];

    // A pending divisor takes over whenever a new period is about to be loaded.
    assign use_pnd  = pnd_valid && (state == IDLE || os_tick);
    assign eff_int  = use_pnd ? pnd_int  : act_int;
    assign eff_frac = use_pnd ? pnd_frac : act_frac;
    assign {carry, acc_sum} = {1'b0, acc} + {1'b0, eff_frac};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            sub   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
            sub   <= sub_nxt;
        end
    end

    always_comb begin
        state_nxt = en ? RUN : IDLE;
        os_tick   = 1'b0;
        mid_tick  = 1'b0;
        bit_tick  = 1'b0;
        cnt_nxt   = '0;
        acc_nxt   = '0;
        sub_nxt   = '0;
        case (state)
            IDLE: begin
                if (en) cnt_nxt = eff_int - DIV_W'(1);
            end
            RUN: begin
                // Dropping en aborts at once: no strobe this cycle, counters cleared.
                if (en) begin
                    os_tick  = (cnt == '0);
                    mid_tick = os_tick && (sub == SUB_MID);
                    bit_tick = os_tick && (sub == SUB_LAST);
                    if (os_tick) begin
                        cnt_nxt = eff_int - DIV_W'(1) + DIV_W'(carry);
                        acc_nxt = acc_sum;
                        sub_nxt = (sub == SUB_LAST) ? '0 : sub + SUB_W'(1);
                    end else begin
                        cnt_nxt = cnt - DIV_W'(1);
                        acc_nxt = acc;
                        sub_nxt = sub;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A load landing in the same cycle as a swap wins, so it waits for the next boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_int   <= RST_INT;
            act_frac  <= RST_FRAC;
            pnd_int   <= '0;
            pnd_frac  <= '0;
            pnd_valid <= 1'b0;
            load_ack  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            load_ack <= 1'b0;
            if (use_pnd) begin
                act_int   <= pnd_int;
                act_frac  <= pnd_frac;
                pnd_valid <= 1'b0;
            end
            if (load) begin
                if (div_int >= DIV_W'(2)) begin
                    pnd_int   <= div_int;
                    pnd_frac  <= div_frac;
                    pnd_valid <= 1'b1;
                    load_ack  <= 1'b1;
                    cfg_err   <= 1'b0;
                end else begin
                    cfg_err   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Randomised and directed bench for baud_tick_gen against a tick-schedule model kept in
// absolute cycle time (next due cycle, accumulated fraction, tick index within the bit).
module tb_baud_tick_gen;

    localparam int OS = 16;
    localparam int FW = 4;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] div_int = '0;
    logic [3:0]  div_frac = '0;
    logic        os_tick, mid_tick, bit_tick, load_ack, cfg_err;

    baud_tick_gen dut (
        .clk      (clk),
        .arst_n   (arst_n),
        .en       (en),
        .load     (load),
        .div_int  (div_int),
        .div_frac (div_frac),
        .os_tick  (os_tick),
        .mid_tick (mid_tick),
        .bit_tick (bit_tick),
        .load_ack (load_ack),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    endtask

    // Model state
    bit     mdl_on = 1'b0;
    bit     rec = 1'b0;
    bit     m_run, m_pv, m_ack, m_err;
    longint m_cyc, m_due;
    int     m_acc, m_sub, m_int, m_frac, m_pint, m_pfrac;
    longint tq[$];

    always @(negedge clk) begin
        if (!mdl_on) begin
            m_run = 0; m_pv = 0; m_ack = 0; m_err = 0;
            m_cyc = 0; m_due = 0; m_acc = 0; m_sub = 0;
            m_int = 325; m_frac = 8; m_pint = 0; m_pfrac = 0;
        end else begin
            bit eo;
            eo = m_run && en && (m_cyc == m_due);
            chk("os_tick",  os_tick,  eo);
            chk("mid_tick", mid_tick, eo && m_sub == OS/2 - 1);
            chk("bit_tick", bit_tick, eo && m_sub == OS - 1);
            chk("load_ack", load_ack, m_ack);
            chk("cfg_err",  cfg_err,  m_err);
            if (rec && os_tick) tq.push_back(m_cyc);
            if (!m_run) begin
                if (m_pv) begin m_int = m_pint; m_frac = m_pfrac; m_pv = 0; end
                if (en) begin
                    m_run = 1; m_due = m_cyc + m_int; m_acc = 0; m_sub = 0;
                end
            end else if (!en) begin
                m_run = 0;
            end else if (eo) begin
                if (m_pv) begin m_int = m_pint; m_frac = m_pfrac; m_pv = 0; end
                m_acc += m_frac;
                m_due = m_cyc + m_int + (m_acc >> FW);
                m_acc = m_acc % (1 << FW);
                m_sub = (m_sub + 1) % OS;
            end
            m_ack = 0;
            if (load) begin
                if (div_int >= 2) begin
                    m_pint = div_int; m_pfrac = div_frac; m_pv = 1; m_ack = 1; m_err = 0;
                end else begin
                    m_err = 1;
                end
            end
            m_cyc++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input int di, input int df);
        div_int = 16'(di);
        div_frac = 4'(df);
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    initial begin
        step(3);
        chk("rst_os",  os_tick,  0);
        chk("rst_mid", mid_tick, 0);
        chk("rst_bit", bit_tick, 0);
        chk("rst_ack", load_ack, 0);
        chk("rst_err", cfg_err,  0);
        arst_n = 1'b1;
        mdl_on = 1'b1;
        step(3);

        // Divisor 4/0: tick every 4, bit every 64
        do_load(4, 0);
        en = 1'b1;
        tq.delete();
        rec = 1'b1;
        step(200);
        rec = 1'b0;
        chk("p4_first", tq[0], tq[0]);
        if (tq.size() >= 20) begin
            chk("p4_period", tq[9] - tq[8], 4);
            chk("p4_16ticks", tq[19] - tq[3], 64);
        end else begin
            chk("p4_count", tq.size(), 20);
        end

        // Divisor 4/8: any 32 consecutive periods span 144 cycles
        do_load(4, 8);
        step(20);
        tq.delete();
        rec = 1'b1;
        step(300);
        rec = 1'b0;
        chk("frac_count_ok", tq.size() > 40, 1);
        for (int i = 0; i + 32 < tq.size(); i++)
            chk("frac_win32", tq[i+32] - tq[i], 144);

        // Rejected then accepted load
        do_load(1, 0);
        step(40);
        do_load(6, 0);
        step(60);

        // en drop after 7 ticks of a fresh run
        en = 1'b0; step(1);
        en = 1'b1; step(43);
        en = 1'b0; step(1);
        en = 1'b1; step(200);

        // Random traffic
        repeat (4000) begin
            en = ($urandom_range(0, 99) < 97);
            load = ($urandom_range(0, 99) < 4);
            div_int = 16'($urandom_range(0, 9));
            div_frac = 4'($urandom);
            step(1);
        end
        load = 1'b0;
        en = 1'b1;
        step(50);

        // Reset in the middle of a run
        mdl_on = 1'b0;
        arst_n = 1'b0;
        #1;
        chk("mrst_os",  os_tick,  0);
        chk("mrst_mid", mid_tick, 0);
        chk("mrst_bit", bit_tick, 0);
        chk("mrst_ack", load_ack, 0);
        chk("mrst_err", cfg_err,  0);
        en = 1'b0;
        step(3);
        arst_n = 1'b1;
        mdl_on = 1'b1;
        step(3);
        en = 1'b1;
        tq.delete();
        rec = 1'b1;
        step(3000);
        rec = 1'b0;
        chk("rst_nticks_ok", tq.size() >= 9, 1);
        for (int i = 0; i + 1 < tq.size(); i++)
            chk("rst_period_325_326", (tq[i+1] - tq[i] == 325) || (tq[i+1] - tq[i] == 326), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
